// File: rtl/vga_core_if.sv
// Video output bundle driven by the VGA timing core toward the DAC/pin drivers.
// The master drives the pixel and syncs; the slave observes them.
interface vga_core_if;
  logic rgb;
  logic hsync;
  logic vsync;

  modport master (output rgb, output hsync, output vsync);
  modport slave  (input  rgb, input  hsync, input  vsync);
endinterface

// File: rtl/vga_core.sv
// VGA raster timing generator with a 1-bit checkerboard test pattern.
// clk is the pixel clock; all outputs are registered one cycle behind the counters.
module vga_core #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CHECK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  vga_core_if.master vga
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int          HW           = $clog2(H_TOTAL);
  localparam int          VW           = $clog2(V_TOTAL);
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          rgb_q, rgb_d;

  logic [31:0] hExt;
  logic [31:0] vExt;
  logic        hWrap;
  logic        vWrap;
  logic        hVis;
  logic        vVis;

  // Region decode is done on 32-bit copies so sync-end bounds equal to a
  // power-of-two total cannot alias back to zero.
  assign hExt  = 32'(h_q);
  assign vExt  = 32'(v_q);
  assign hWrap = (hExt == H_TOTAL - 1);
  assign vWrap = (vExt == V_TOTAL - 1);
  assign hVis  = (hExt < 32'(H_VISIBLE));
  assign vVis  = (vExt < 32'(V_VISIBLE));

  always_comb begin
    h_d     = h_q + 1'b1;
    v_d     = v_q;
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    rgb_d   = 1'b0;

    if (hWrap) begin
      h_d = '0;
      v_d = vWrap ? '0 : v_q + 1'b1;
    end

    if ((hExt >= H_SYNC_START) && (hExt < H_SYNC_END)) begin
      hsync_d = 1'b0;
    end
    if ((vExt >= V_SYNC_START) && (vExt < V_SYNC_END)) begin
      vsync_d = 1'b0;
    end
    if (hVis && vVis) begin
      rgb_d = h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.rgb   = rgb_q;
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;

endmodule

// File: tb/tb_vga_core.sv
// Bench for vga_core: a default-timing instance checked against hand-computed
// vectors, and a small-timing instance checked every pixel over many frames.
module tb_vga_core;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vga_core_if defIf ();
  vga_core_if smIf ();

  vga_core dutDef (
    .clk   (clk),
    .reset (reset),
    .vga   (defIf.master)
  );

  vga_core #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .CHECK_LOG2 (1)
  ) dutSm (
    .clk   (clk),
    .reset (reset),
    .vga   (smIf.master)
  );

  typedef struct packed {
    logic [31:0] edgeNum;
    logic        rgb;
    logic        hsync;
    logic        vsync;
  } vecT;

  // Edge n after reset release shows the outputs for pixel index n-1.
  localparam int NUM_VECS = 23;
  vecT defVecs [NUM_VECS] = '{
    '{32'd1,     1'b0, 1'b1, 1'b1},
    '{32'd32,    1'b0, 1'b1, 1'b1},
    '{32'd33,    1'b1, 1'b1, 1'b1},
    '{32'd64,    1'b1, 1'b1, 1'b1},
    '{32'd65,    1'b0, 1'b1, 1'b1},
    '{32'd640,   1'b1, 1'b1, 1'b1},
    '{32'd641,   1'b0, 1'b1, 1'b1},
    '{32'd656,   1'b0, 1'b1, 1'b1},
    '{32'd657,   1'b0, 1'b0, 1'b1},
    '{32'd752,   1'b0, 1'b0, 1'b1},
    '{32'd753,   1'b0, 1'b1, 1'b1},
    '{32'd800,   1'b0, 1'b1, 1'b1},
    '{32'd801,   1'b0, 1'b1, 1'b1},
    '{32'd833,   1'b1, 1'b1, 1'b1},
    '{32'd1457,  1'b0, 1'b0, 1'b1},
    '{32'd1553,  1'b0, 1'b1, 1'b1},
    '{32'd24801, 1'b0, 1'b1, 1'b1},
    '{32'd25601, 1'b1, 1'b1, 1'b1},
    '{32'd25633, 1'b0, 1'b1, 1'b1},
    '{32'd25665, 1'b1, 1'b1, 1'b1},
    '{32'd26240, 1'b0, 1'b1, 1'b1},
    '{32'd26241, 1'b0, 1'b1, 1'b1},
    '{32'd27101, 1'b0, 1'b0, 1'b1}
  };

  int checkCount = 0;
  int errorCount = 0;
  int edgeCnt;
  int vecIdx;
  int smFallCount;
  int smVsLowCount;
  logic smPrevVs;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_def_rgb"},   32'(defIf.rgb),   32'd0);
    checkOutput({tag, "_def_hsync"}, 32'(defIf.hsync), 32'd1);
    checkOutput({tag, "_def_vsync"}, 32'(defIf.vsync), 32'd1);
    checkOutput({tag, "_sm_rgb"},    32'(smIf.rgb),    32'd0);
    checkOutput({tag, "_sm_hsync"},  32'(smIf.hsync),  32'd1);
    checkOutput({tag, "_sm_vsync"},  32'(smIf.vsync),  32'd1);
  endtask

  // Small timing: 14 pixels per line, 7 lines per frame, 2-pixel checker squares.
  task automatic checkSmallPixel();
    int p, hs, vs;
    logic expRgb, expHs, expVs;
    p  = edgeCnt - 1;
    hs = p % 14;
    vs = (p / 14) % 7;
    expRgb = (hs < 8 && vs < 4) ? 1'(((hs / 2) + (vs / 2)) % 2) : 1'b0;
    expHs  = (hs == 10 || hs == 11) ? 1'b0 : 1'b1;
    expVs  = (vs == 5) ? 1'b0 : 1'b1;
    checkOutput($sformatf("sm_rgb@%0d", edgeCnt),   32'(smIf.rgb),   32'(expRgb));
    checkOutput($sformatf("sm_hsync@%0d", edgeCnt), 32'(smIf.hsync), 32'(expHs));
    checkOutput($sformatf("sm_vsync@%0d", edgeCnt), 32'(smIf.vsync), 32'(expVs));

    if (edgeCnt <= 98 && smIf.vsync == 1'b0) smVsLowCount++;
    if (edgeCnt == 98) checkOutput("sm_vsync_low_len", 32'(smVsLowCount), 32'd14);
    if (smPrevVs == 1'b1 && smIf.vsync == 1'b0) begin
      smFallCount++;
      if (smFallCount == 1) checkOutput("sm_vsync_fall1", 32'(edgeCnt), 32'd71);
      if (smFallCount == 2) checkOutput("sm_vsync_fall2", 32'(edgeCnt), 32'd169);
    end
    smPrevVs = smIf.vsync;
  endtask

  // Advance to the given edge count, sampling each cycle on the falling edge.
  task automatic applyStimulus(input int lastEdge);
    while (edgeCnt < lastEdge) begin
      @(posedge clk);
      @(negedge clk);
      edgeCnt++;
      if (vecIdx < NUM_VECS && defVecs[vecIdx].edgeNum == 32'(edgeCnt)) begin
        checkOutput($sformatf("def_rgb@%0d", edgeCnt),
                    32'(defIf.rgb), 32'(defVecs[vecIdx].rgb));
        checkOutput($sformatf("def_hsync@%0d", edgeCnt),
                    32'(defIf.hsync), 32'(defVecs[vecIdx].hsync));
        checkOutput($sformatf("def_vsync@%0d", edgeCnt),
                    32'(defIf.vsync), 32'(defVecs[vecIdx].vsync));
        vecIdx++;
      end
      checkSmallPixel();
    end
  endtask

  task automatic releaseReset();
    reset        = 1'b1;
    edgeCnt      = 0;
    vecIdx       = 0;
    smFallCount  = 0;
    smVsLowCount = 0;
    smPrevVs     = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkAllIdle($sformatf("rst%0d", i));
    end
    releaseReset();
    applyStimulus(27101);

    // Abort mid-line while both instances are inside their hsync pulses.
    #2 reset = 1'b0;
    #1 checkAllIdle("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkAllIdle($sformatf("midrst%0d", i));
    end
    releaseReset();
    applyStimulus(1553);
    checkOutput("restart_vecs_seen", 32'(vecIdx), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
